// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM states, default
// geometry, the FIFO entry layout and a lowest-set-bit search.
package adc_pkg;

  localparam int NCH_DEF  = 8;
  localparam int CH_W_DEF = 3;
  localparam int RES_DEF  = 10;
  localparam int MAX_NCH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    CONVERT,
    NEXT
  } scan_state_t;

  typedef struct packed {
    logic [CH_W_DEF-1:0] ch;
    logic [RES_DEF-1:0]  data;
  } adc_entry_t;

  // Lowest set bit of mask at or above index 'from'; -1 when there is none.
  function automatic int next_set_bit(input logic [MAX_NCH-1:0] mask, input int from);
    int r;
    r = -1;
    for (int i = MAX_NCH - 1; i >= 0; i--) begin
      if ((i >= from) && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Small synchronous FIFO for {channel, result} entries. A write while full
// is accepted only when a pop happens in the same cycle.
module adc_result_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Head is forced to zero while empty so stale storage never shows after a flush.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel SAR scan sequencer: walks the channel mask, times the sample
// window, fires conversions, watches for eoc and queues the results.
//
// state   | meaning
// IDLE    | waiting for start with a nonzero mask
// SETTLE  | one cycle with the mux switched and the sample switch open
// SAMPLE  | sample switch closed for max(sample_cycles,1) cycles
// CONVERT | soc on the first cycle, then wait for eoc or the watchdog
// NEXT    | pick the next channel, wrap in continuous mode, or stop
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int CH_W       = CH_W_DEF,
  parameter int RES        = RES_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                cont,
  input  logic                stop,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [7:0]          sample_cycles,
  output logic [CH_W-1:0]     adc_sel,
  output logic                adc_sample,
  output logic                adc_soc,
  input  logic                adc_eoc,
  input  logic [RES-1:0]      adc_data,
  input  logic                fifo_rd,
  output logic [CH_W+RES-1:0] fifo_dout,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                overflow,
  output logic                timeout_err,
  input  logic                err_clr,
  output logic                busy,
  output logic                scan_done
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (TO_W > 8) ? TO_W : 8;

  scan_state_t        state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CH_W-1:0]    ch_q, ch_n;
  logic [NCH-1:0]     mask_q, mask_n;
  logic               stop_pend, stop_pend_n;
  logic               done_q, done_n;
  logic               overflow_q, timeout_q;
  logic               set_ovf, set_to;
  logic               fifo_wr;
  logic               soc_cyc;
  logic               stop_eff;
  logic [MAX_NCH-1:0] new_mask_ext;
  logic [MAX_NCH-1:0] cur_mask_ext;

  always_comb begin
    new_mask_ext = '0;
    cur_mask_ext = '0;
    new_mask_ext[NCH-1:0] = ch_mask;
    cur_mask_ext[NCH-1:0] = mask_q;
  end

  assign stop_eff = stop || stop_pend;
  assign soc_cyc  = (state == CONVERT) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ch_n       = ch_q;
    mask_n     = mask_q;
    done_n     = 1'b0;
    fifo_wr    = 1'b0;
    set_ovf    = 1'b0;
    set_to     = 1'b0;
    adc_sample = 1'b0;
    adc_soc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_n  = ch_mask;
          ch_n    = CH_W'(next_set_bit(new_mask_ext, 0));
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (stop_eff) begin
          state_n = IDLE;
        end else begin
          cnt_n   = (sample_cycles == 8'd0) ? '0 : CNT_W'(sample_cycles - 8'd1);
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        adc_sample = 1'b1;
        if (stop_eff) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          cnt_n   = CNT_W'(TIMEOUT - 1);
          state_n = CONVERT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CONVERT: begin
        adc_soc = soc_cyc;
        // eoc wins over the watchdog on its final cycle
        if (adc_eoc && !soc_cyc) begin
          fifo_wr = 1'b1;
          set_ovf = fifo_full && !fifo_rd;
          state_n = NEXT;
        end else if (cnt == '0) begin
          set_to  = 1'b1;
          state_n = NEXT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      NEXT: begin
        if (stop_eff) begin
          state_n = IDLE;
        end else if (next_set_bit(cur_mask_ext, int'(ch_q) + 1) >= 0) begin
          ch_n    = CH_W'(next_set_bit(cur_mask_ext, int'(ch_q) + 1));
          state_n = SETTLE;
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
          if (cont && (ch_mask != '0)) begin
            mask_n  = ch_mask;
            ch_n    = CH_W'(next_set_bit(new_mask_ext, 0));
            state_n = SETTLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A stop seen while scanning is held until the FSM reaches a point that honours it.
  always_comb begin
    stop_pend_n = stop_pend;
    if (state_n == IDLE)                stop_pend_n = 1'b0;
    else if (stop && (state != IDLE))   stop_pend_n = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt         <= '0;
      ch_q        <= '0;
      mask_q      <= '0;
      stop_pend   <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      ch_q      <= ch_n;
      mask_q    <= mask_n;
      stop_pend <= stop_pend_n;
      done_q    <= done_n;
      if (err_clr)      overflow_q <= 1'b0;
      else if (set_ovf) overflow_q <= 1'b1;
      if (err_clr)      timeout_q  <= 1'b0;
      else if (set_to)  timeout_q  <= 1'b1;
    end
  end

  adc_result_fifo #(
    .WIDTH (CH_W + RES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .wr    (fifo_wr),
    .din   ({ch_q, adc_data}),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign adc_sel     = ch_q;
  assign busy        = (state != IDLE);
  assign scan_done   = done_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: a SAR responder and reference FIFO
// model push expected entries, a separate monitor checks every pop.
module tb_adc_scan_ctrl;
  import adc_pkg::*;

  localparam int NCH = 8, CH_W = 3, RES = 10, DEPTH = 4, TIMEOUT = 255;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i = 1'b1;
  logic                start = 1'b0, cont = 1'b0, stop = 1'b0, err_clr = 1'b0;
  logic [NCH-1:0]      ch_mask = '0;
  logic [7:0]          sample_cycles = 8'd1;
  logic                adc_eoc = 1'b0;
  logic [RES-1:0]      adc_data = '0;
  logic                fifo_rd = 1'b0;
  logic [CH_W-1:0]     adc_sel;
  logic                adc_sample, adc_soc, fifo_empty, fifo_full;
  logic                overflow, timeout_err, busy, scan_done;
  logic [CH_W+RES-1:0] fifo_dout;

  adc_scan_ctrl #(.NCH(NCH), .CH_W(CH_W), .RES(RES), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .cont(cont), .stop(stop),
    .ch_mask(ch_mask), .sample_cycles(sample_cycles), .adc_sel(adc_sel),
    .adc_sample(adc_sample), .adc_soc(adc_soc), .adc_eoc(adc_eoc), .adc_data(adc_data),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy),
    .scan_done(scan_done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int         checks = 0, errors = 0;
  adc_entry_t exp_q[$];
  int         exp_ch_q[$];
  int         occ = 0, soc_cnt = 0, done_cnt = 0, hang_ch = -1, fixed_dly = 0;
  int         exp_smp = 1, smp_run = 0, eoc_wait = 0, cur_ch = 0;
  bit         rd_en = 0, rd_all = 0, chk_sample = 1, exp_ovf = 0, prev_soc = 0;
  logic [RES-1:0] cur_data = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // SAR responder + reference FIFO occupancy model.
  always @(negedge wb_clk_i) begin : drv
    bit         pop;
    adc_entry_t ne;
    if (wb_rst_i) begin
      adc_eoc = 0; eoc_wait = 0; occ = 0; smp_run = 0; prev_soc = 0; fifo_rd = 0;
    end else begin
      if (adc_sample) smp_run++;
      else if (smp_run > 0) begin
        if (chk_sample) chk("sample_len", smp_run, exp_smp);
        smp_run = 0;
      end
      adc_eoc = 0;
      if (adc_soc) begin
        soc_cnt++;
        chk("soc_single", prev_soc, 0);
        if (exp_ch_q.size() == 0 && cont)
          for (int i = 0; i < NCH; i++) if (ch_mask[i]) exp_ch_q.push_back(i);
        cur_ch = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
        chk("adc_sel", adc_sel, cur_ch);
        if (cur_ch != hang_ch) begin
          eoc_wait = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(3, 20));
          cur_data = RES'($urandom);
        end
      end else if (eoc_wait > 0) begin
        eoc_wait--;
        if (eoc_wait == 0) begin
          adc_eoc  = 1;
          adc_data = cur_data;
        end
      end
      prev_soc = adc_soc;
      fifo_rd = rd_all || (rd_en && ($urandom_range(0, 2) == 0));
      pop = fifo_rd && (occ > 0);
      if (adc_eoc) begin
        if (occ < DEPTH || pop) begin
          ne.ch = CH_W'(cur_ch);
          ne.data = cur_data;
          exp_q.push_back(ne);
          occ++;
        end else exp_ovf = 1;
      end
      if (pop) occ--;
    end
  end

  // Monitor: compares every accepted pop against the scoreboard head.
  always @(negedge wb_clk_i) begin : mon
    adc_entry_t e;
    #2;
    if (scan_done) done_cnt++;
    if (!wb_rst_i && fifo_rd && !fifo_empty) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fifo_pop got %0h expected no entry", fifo_dout);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_dout", fifo_dout, e);
      end
    end
  end

  task automatic pulse_start(input logic [NCH-1:0] m, input bit expect_scan);
    if (expect_scan) for (int i = 0; i < NCH; i++) if (m[i]) exp_ch_q.push_back(i);
    ch_mask = m; start = 1;
    @(negedge wb_clk_i);
    start = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge wb_clk_i); n++; end while (busy && n < 3000);
    chk(name, busy, 0);
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic drain(input string name);
    int n = 0;
    rd_all = 1;
    while ((occ > 0 || !fifo_empty) && n < 200) begin @(negedge wb_clk_i); n++; end
    repeat (2) @(negedge wb_clk_i);
    rd_all = 0;
    chk({name, "_sb_left"}, exp_q.size(), 0);
    chk({name, "_empty"}, fifo_empty, 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1; @(negedge wb_clk_i); err_clr = 0; @(negedge wb_clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int base, sb, n;
    logic [NCH-1:0] m;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_busy", busy, 0);       chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);  chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout_err, 0);  chk("rst_soc", adc_soc, 0);
    chk("rst_sample", adc_sample, 0); chk("rst_done", scan_done, 0);
    chk("rst_sel", adc_sel, 0);     chk("rst_dout", fifo_dout, 0);
    wb_rst_i = 0;
    @(negedge wb_clk_i);

    // Directed single scan over channels 0,5,7.
    sample_cycles = 3; exp_smp = 3; fixed_dly = 12; rd_en = 1;
    base = done_cnt; sb = soc_cnt;
    pulse_start(8'hA1, 1);
    wait_idle("t1_idle");
    chk("t1_done", done_cnt - base, 1);
    chk("t1_socs", soc_cnt - sb, 3);
    drain("t1");

    // Zero sample window behaves as one cycle.
    sample_cycles = 0; exp_smp = 1; fixed_dly = 0;
    base = done_cnt; sb = soc_cnt;
    pulse_start(8'h01, 1);
    wait_idle("t2_idle");
    chk("t2_done", done_cnt - base, 1);
    chk("t2_socs", soc_cnt - sb, 1);
    drain("t2");

    // Random single scans with a start issued while busy.
    for (int it = 0; it < 8; it++) begin
      m = NCH'($urandom_range(1, 255));
      sample_cycles = 8'($urandom_range(0, 4));
      exp_smp = (sample_cycles == 0) ? 1 : int'(sample_cycles);
      base = done_cnt; sb = soc_cnt;
      pulse_start(m, 1);
      repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
      pulse_start(~m | 8'h01, 0);
      wait_idle("t3_idle");
      chk("t3_done", done_cnt - base, 1);
      chk("t3_socs", soc_cnt - sb, $countones(m));
      chk("t3_chq", exp_ch_q.size(), 0);
      drain("t3");
    end

    // Continuous scan with no reads: FIFO fills, later results are dropped.
    rd_en = 0; cont = 1; sample_cycles = 1; exp_smp = 1; exp_ovf = 0;
    base = done_cnt; sb = soc_cnt;
    pulse_start(8'hFF, 1);
    n = 0;
    while (soc_cnt < sb + 10 && n < 3000) begin @(negedge wb_clk_i); n++; end
    stop = 1; @(negedge wb_clk_i); stop = 0; cont = 0;
    wait_idle("t4_idle");
    chk("t4_socs", soc_cnt - sb, 10);
    chk("t4_done", done_cnt - base, 1);
    chk("t4_full", fifo_full, 1);
    chk("t4_ovf", overflow, exp_ovf);
    chk("t4_ovf_set", overflow, 1);
    exp_ch_q.delete();
    drain("t4");
    pulse_clr();
    chk("t4_ovf_clr", overflow, 0);
    exp_ovf = 0;

    // Channel 2 never answers: watchdog fires after TIMEOUT cycles.
    hang_ch = 2; rd_en = 1; sample_cycles = 2; exp_smp = 2;
    base = done_cnt; sb = soc_cnt;
    pulse_start(8'h0C, 1);
    n = 0;
    while (!(adc_soc && adc_sel == 2) && n < 200) begin @(negedge wb_clk_i); n++; end
    chk("t5_soc2_seen", adc_soc, 1);
    repeat (TIMEOUT - 1) @(negedge wb_clk_i);
    chk("t5_to_early", timeout_err, 0);
    @(negedge wb_clk_i);
    chk("t5_to_set", timeout_err, 1);
    wait_idle("t5_idle");
    chk("t5_done", done_cnt - base, 1);
    chk("t5_socs", soc_cnt - sb, 2);
    drain("t5");
    hang_ch = -1;
    pulse_clr();
    chk("t5_to_clr", timeout_err, 0);

    // Stop during SAMPLE of the second channel in continuous mode.
    cont = 1; sample_cycles = 6; exp_smp = 6;
    base = done_cnt;
    pulse_start(8'h12, 1);
    n = 0;
    while (!(adc_sample && adc_sel == 4) && n < 500) begin @(negedge wb_clk_i); n++; end
    chk("t6_in_sample", adc_sample, 1);
    chk_sample = 0; sb = soc_cnt;
    stop = 1; @(negedge wb_clk_i); stop = 0;
    chk("t6_busy", busy, 0);
    chk("t6_sample", adc_sample, 0);
    cont = 0;
    repeat (5) @(negedge wb_clk_i);
    chk("t6_no_soc", soc_cnt - sb, 0);
    chk("t6_no_done", done_cnt - base, 0);
    chk_sample = 1;
    exp_ch_q.delete();
    drain("t6");

    // Reset in the middle of the third conversion with two entries queued.
    rd_en = 0; sample_cycles = 1; exp_smp = 1; fixed_dly = 8;
    sb = soc_cnt;
    pulse_start(8'h07, 1);
    n = 0;
    while (soc_cnt < sb + 3 && n < 500) begin @(negedge wb_clk_i); n++; end
    chk("t7_pre_empty", fifo_empty, 0);
    chk("t7_pre_busy", busy, 1);
    #2 wb_rst_i = 1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_empty", fifo_empty, 1);
    chk("t7_soc", adc_soc, 0);
    chk("t7_sample", adc_sample, 0);
    exp_q.delete(); exp_ch_q.delete();
    repeat (3) @(negedge wb_clk_i);
    fixed_dly = 0; wb_rst_i = 0;
    @(negedge wb_clk_i);
    base = done_cnt; sb = soc_cnt;
    pulse_start('0, 0);
    repeat (4) @(negedge wb_clk_i);
    chk("t7_zero_busy", busy, 0);
    chk("t7_zero_done", done_cnt - base, 0);
    chk("t7_zero_soc", soc_cnt - sb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Multi-channel scan sequencer for the SAR ADC macro.
- Walks an enabled-channel mask, drives the analog mux select, holds the sample window, starts each conversion and waits for end-of-conversion.
- Pushes each {channel, result} into a small FIFO that the Wishbone register block drains.
- Sits inside adc_wrapper, between the register block and the SAR core; clocked from wb_clk_i.

Parameters:
- NCH, 8, number of analog channels (power of two, 2..16)
- CH_W, 3, channel index width = log2(NCH)
- RES, 10, ADC result width
- FIFO_DEPTH, 4, result FIFO entries (power of two)
- TIMEOUT, 255, max cycles to wait for adc_eoc

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a scan when idle
- cont  in  1  1 = rescan continuously until stop
- stop  in  1  one-cycle pulse; finish the current conversion, then go idle
- ch_mask  in  NCH  enabled channels; sampled at scan start
- sample_cycles  in  8  sample window length; 0 is treated as 1
- adc_sel  out  CH_W  analog mux channel select
- adc_sample  out  1  sample switch closed
- adc_soc  out  1  start-of-conversion pulse
- adc_eoc  in  1  end-of-conversion pulse from the SAR core
- adc_data  in  RES  conversion result, valid with adc_eoc
- fifo_rd  in  1  pop request
- fifo_dout  out  CH_W+RES  {channel, result} at the FIFO head
- fifo_empty  out  1  FIFO empty
- fifo_full  out  1  FIFO full
- overflow  out  1  sticky: a result was dropped
- timeout_err  out  1  sticky: adc_eoc missing
- err_clr  in  1  clears overflow and timeout_err
- busy  out  1  state != IDLE
- scan_done  out  1  one-cycle pulse at the end of each scan pass

Behaviour:
- Reset values: all outputs 0 except fifo_empty=1. FSM = IDLE, FIFO pointers = 0.
- IDLE -> SETTLE on start when the latched mask is nonzero.
  - A start with mask == 0 is ignored: no state change, no scan_done.
- Channel order: ascending from the lowest set bit. adc_sel updates on entry to SETTLE.
- SETTLE: exactly 1 cycle, adc_sample=0 -> SAMPLE.
- SAMPLE: adc_sample=1 for max(sample_cycles,1) cycles -> CONVERT.
- CONVERT: adc_soc=1 on the first cycle only; adc_sample=0. Wait for adc_eoc.
  - An eoc in the same cycle as soc is ignored.
  - Watchdog counts from soc. If it reaches TIMEOUT cycles without eoc: set timeout_err, write no FIFO entry, proceed as if the result had been stored.
- On adc_eoc: capture {adc_sel, adc_data} into the FIFO in the same edge -> NEXT.
  - If the FIFO is full and fifo_rd is not asserted that cycle: drop the entry, set overflow.
  - A simultaneous rd and wr while full succeeds.
- NEXT: select the next higher set bit of the latched mask -> SETTLE.
  - If none remains: pulse scan_done.
  - Then, if cont=1 and no stop is pending: relatch ch_mask and restart from the lowest bit. A relatched mask of 0 -> IDLE.
  - Otherwise -> IDLE.
- stop: recorded as pending in any non-IDLE state.
  - Takes effect after the current channel's conversion or timeout completes (at NEXT): -> IDLE, no scan_done.
  - A stop during SETTLE or SAMPLE aborts immediately to IDLE with adc_sample=0 and no soc.
- start while busy is ignored.
- FIFO:
  - fifo_dout shows the head combinationally.
  - Pop on fifo_rd when not empty; a pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full from empty.
- Sticky flags: err_clr wins over a same-cycle set.
- Async reset mid-conversion returns to IDLE immediately and flushes the FIFO. adc_soc and adc_sample drop asynchronously.

Decomposition:
- Package adc_pkg:
  - FSM state enum (IDLE, SETTLE, SAMPLE, CONVERT, NEXT)
  - NCH/CH_W/RES defaults
  - result entry typedef {ch, data}
- Sub-module adc_result_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with full/empty and simultaneous rd/wr handling.
- A priority "next set bit above index" function lives in the package.

Test Plan:
- Single scan, mask=8'b1010_0001, sample_cycles=3, eoc 12 cycles after soc.
  - Expect adc_sel sequence 0,5,7; adc_sample high for 3 cycles each.
  - Expect 3 FIFO entries {0,d0},{5,d5},{7,d7} and one scan_done; busy low afterwards.
- sample_cycles=0, mask=8'h01 -> adc_sample high exactly 1 cycle; adc_soc high exactly 1 cycle.
- Continuous scan, mask=8'hFF, no reads, FIFO_DEPTH=4.
  - Expect 4 entries, overflow=1, fifo_full=1, no corruption of the head.
  - err_clr then drops overflow.
- SAR never returns eoc on channel 2, mask=8'h0C.
  - Expect timeout_err=1 after 255 cycles, no entry for channel 2.
  - Channel 3 converts normally; scan_done pulses.
- stop during SAMPLE of the 2nd channel in continuous mode -> IDLE next cycle, adc_sample=0, no soc, no scan_done.
- wb_rst_i asserted mid-CONVERT with 2 FIFO entries -> busy=0, fifo_empty=1, adc_soc=0 immediately.
  - After release, start with mask=0 is ignored.
